// File: rtl/spcpu_fetch_unit_pkg.sv
// Shared definitions for the halfword fetch unit: instruction-length
// encoding and the helper that classifies a first halfword.
package pkg_fetch;

    // A first halfword whose top three bits are all ones starts a 32-bit
    // instruction; anything else is a complete 16-bit instruction.
    localparam logic [15:0] LEN32_MASK  = 16'hE000;
    localparam logic [15:0] LEN32_MATCH = 16'hE000;

    function automatic logic is_32_bit(input logic [15:0] hi);
        return (hi & LEN32_MASK) == LEN32_MATCH;
    endfunction

endpackage

// File: rtl/spcpu_fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment: redirect input,
// halfword memory read port and the instruction delivery handshake.
// The master modport is the fetch unit side, the slave modport the
// core/memory side.
interface spcpu_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr_hi;
    logic [15:0]       instr_lo;
    logic              instr_is_32;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_hi, instr_lo, instr_is_32, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_hi, instr_lo, instr_is_32, instr_pc
    );

endinterface

// File: rtl/spcpu_fetch_queue.sv
// Circular halfword queue with per-entry address tags. Supports one push
// and a pop of one or two entries per cycle; flush empties it at once.
// Entry storage is not reset: the occupancy count decides what is visible.
module spcpu_fetch_queue #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [15:0]                  push_data,
    input  logic                         pop1,
    input  logic                         pop2,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [15:0]                  head_data,
    output logic [15:0]                  next_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [15:0]       data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  pop_cnt;

    assign pop_cnt   = pop2 ? CNT_W'(2) : CNT_W'(pop1);
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];
    assign next_data = data_q[rd_ptr + PTR_W'(1)];

    // Tail write of the returned halfword and its address tag.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_addr;
            data_q[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy update; power-of-two depth lets pointers wrap freely.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop2)
                rd_ptr <= rd_ptr + PTR_W'(2);
            else if (pop1)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - pop_cnt;
        end
    end

endmodule

// File: rtl/spcpu_fetch_unit.sv
// Halfword instruction fetch unit: issues one outstanding halfword read at
// a time, collects responses in a tagged queue and presents complete 16- or
// 32-bit instructions on a valid/ready handshake. Redirects flush the queue
// and mark an in-flight response as stale so it is dropped on arrival.
// Optional build macro SPCPU_FETCH_PERF_CNT_EN adds the fetch_stall_cnt
// output counting cycles the consumer was ready but no instruction was.
module spcpu_fetch_unit
    import pkg_fetch::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'h8000)
) (
    input  logic                clk,
    input  logic                reset,
    spcpu_fetch_unit_if.master  bus
`ifdef SPCPU_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_stall_cnt
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_addr;
    logic              pending;
    logic              stale;
    logic              redirect;
    logic              head_is_32;
    logic              instr_avail;
    logic              pop;
    logic              issue;
    logic              ack_accept;
    logic              q_push;
    logic              q_pop1;
    logic              q_pop2;
    logic [ADDR_W-1:0] head_addr;
    logic [15:0]       head_data;
    logic [15:0]       next_data;
    logic [CNT_W-1:0]  q_count;
    logic [CNT_W-1:0]  count_after_pop;
    logic              unused_redirect_lsb;

    assign redirect            = bus.redirect_valid;
    assign unused_redirect_lsb = bus.redirect_pc[0];

    // Head decode and delivery: a 32-bit head needs both halfwords present;
    // redirect and reset hide the head for the cycle.
    always_comb begin
        head_is_32      = (q_count != '0) && is_32_bit(head_data);
        instr_avail     = head_is_32 ? (q_count >= CNT_W'(2)) : (q_count != '0);
        bus.instr_valid = instr_avail && !redirect && !reset;
        pop             = bus.instr_valid && bus.instr_ready;
        q_pop1          = pop && !head_is_32;
        q_pop2          = pop && head_is_32;
        bus.instr_is_32 = head_is_32;
        bus.instr_hi    = (q_count != '0) ? head_data : 16'h0000;
        bus.instr_lo    = (head_is_32 && (q_count >= CNT_W'(2))) ? next_data : 16'h0000;
        bus.instr_pc    = (q_count != '0) ? head_addr : fetch_pc;
    end

    // Request side: a new read goes out when nothing is in flight and the
    // queue has room once this cycle's pop is taken into account. An
    // in-flight request keeps its original address even after a redirect.
    always_comb begin
        count_after_pop = q_count - (q_pop2 ? CNT_W'(2) : CNT_W'(q_pop1));
        issue           = !pending && !redirect && !reset
                          && (count_after_pop < CNT_W'(DEPTH));
        bus.mem_req     = !reset && (pending || issue);
        bus.mem_addr    = pending ? req_addr : fetch_pc;
        ack_accept      = bus.mem_ack && bus.mem_req;
        q_push          = ack_accept && !stale && !redirect;
    end

    // Fetch control: outstanding flag, stale marker and fetch address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 1'b0;
            stale    <= 1'b0;
            fetch_pc <= RESET_PC;
        end else begin
            pending <= bus.mem_req && !bus.mem_ack;
            if (redirect) begin
                fetch_pc <= {bus.redirect_pc[ADDR_W-1:1], 1'b0};
                stale    <= pending && !bus.mem_ack;
            end else if (ack_accept) begin
                stale <= 1'b0;
                if (!stale)
                    fetch_pc <= fetch_pc + ADDR_W'(2);
            end
        end
    end

    // Capture the address of a newly issued request so it holds until ack.
    always_ff @(posedge clk) begin
        if (issue)
            req_addr <= fetch_pc;
    end

    spcpu_fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (q_push),
        .push_addr (bus.mem_addr),
        .push_data (bus.mem_rdata),
        .pop1      (q_pop1),
        .pop2      (q_pop2),
        .head_addr (head_addr),
        .head_data (head_data),
        .next_data (next_data),
        .count     (q_count)
    );

`ifdef SPCPU_FETCH_PERF_CNT_EN
    // Saturating count of cycles the consumer waited on an instruction.
    always_ff @(posedge clk) begin
        if (reset)
            fetch_stall_cnt <= '0;
        else if (bus.instr_ready && !bus.instr_valid && (fetch_stall_cnt != '1))
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_spcpu_fetch_unit.sv
// Directed bench for spcpu_fetch_unit with a latency-configurable halfword
// memory model and a queue of expected instructions.
module tb_spcpu_fetch_unit;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        is32;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    spcpu_fetch_unit_if #(.ADDR_W(16)) bus ();

`ifdef SPCPU_FETCH_PERF_CNT_EN
    logic [31:0] fetch_stall_cnt;
`endif

    spcpu_fetch_unit #(
        .ADDR_W   (16),
        .DEPTH    (4),
        .RESET_PC (16'h8000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SPCPU_FETCH_PERF_CNT_EN
        ,
        .fetch_stall_cnt (fetch_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [15:0] mem_img [logic [15:0]];
    int          ack_lat = 0;
    int          wait_cnt = 0;
    int          ack_cnt = 0;
    logic [15:0] last_ack_addr = 16'h0000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem_img.exists(a))
            return mem_img[a];
        return {4'h1, a[12:1]};
    endfunction

    // Expected instruction sequence starting at a given address.
    task automatic expect_stream(input logic [15:0] start, input int n);
        logic [15:0] pc;
        exp_t        e;
        pc = start;
        for (int i = 0; i < n; i++) begin
            e.pc = pc;
            e.hi = mem_rd(pc);
            if (e.hi[15:13] == 3'b111) begin
                e.lo   = mem_rd(pc + 16'd2);
                e.is32 = 1'b1;
                pc     = pc + 16'd4;
            end else begin
                e.lo   = 16'h0000;
                e.is32 = 1'b0;
                pc     = pc + 16'd2;
            end
            sb.push_back(e);
        end
    endtask

    // One clock: memory responds at negedge, deliveries are scored, and the
    // consumer stops accepting once nothing more is expected.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.mem_req === 1'b1) begin
            if (wait_cnt >= ack_lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_rd(bus.mem_addr);
                last_ack_addr = bus.mem_addr;
                ack_cnt++;
                wait_cnt = 0;
            end else begin
                bus.mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end
        #1;
        if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_instr_pc", 64'(bus.instr_pc), 64'hDEAD_0000_0000_0000);
            end else begin
                e = sb.pop_front();
                check("instr", 64'({bus.instr_pc, bus.instr_hi, bus.instr_lo, bus.instr_is_32}), 64'(e));
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0)
            bus.instr_ready = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic reset_dut();
        sb.delete();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        bus.mem_ack        = 1'b0;
        bus.mem_rdata      = 16'h0000;
        bus.instr_ready    = 1'b0;
        reset              = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        reset_dut();
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_instr_hi", 64'(bus.instr_hi), 64'd0);
        check("rst_instr_lo", 64'(bus.instr_lo), 64'd0);
        check("rst_instr_is_32", 64'(bus.instr_is_32), 64'd0);
        check("rst_instr_pc", 64'(bus.instr_pc), 64'h8000);
`ifdef SPCPU_FETCH_PERF_CNT_EN
        check("rst_stall_cnt", 64'(fetch_stall_cnt), 64'd0);
`endif

        // Two 16-bit instructions, memory acking in the request cycle
        ack_lat = 0;
        mem_img[16'h8000] = 16'h1234;
        mem_img[16'h8002] = 16'h5678;
        expect_stream(16'h8000, 2);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        #1;
        check("first_req", 64'(bus.mem_req), 64'd1);
        check("first_addr", 64'(bus.mem_addr), 64'h8000);
        drain("drain_16bit", 20);

        // One 32-bit instruction followed by a 16-bit one
        mem_img[16'h8000] = 16'hE001;
        mem_img[16'h8002] = 16'hBEEF;
        reset_dut();
        expect_stream(16'h8000, 2);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        drain("drain_32bit", 20);

        // Backpressure: queue fills to DEPTH, a single pop reopens fetch
        mem_img.delete();
        ack_lat = 1;
        reset_dut();
        reset   = 1'b0;
        ack_cnt = 0;
        repeat (14) tick();
        check("fill_acks", 64'(ack_cnt), 64'd4);
        check("fill_req", 64'(bus.mem_req), 64'd0);
        check("fill_valid", 64'(bus.instr_valid), 64'd1);
        expect_stream(16'h8000, 1);
        bus.instr_ready = 1'b1;
        #1;
        check("pop_req_same", 64'(bus.mem_req), 64'd1);
        tick();
        check("pop_req_next", 64'(bus.mem_req), 64'd1);
        check("pop_addr", 64'(bus.mem_addr), 64'h8008);
        tick();
        tick();
        check("refill_acks", 64'(ack_cnt), 64'd5);
        check("refill_req", 64'(bus.mem_req), 64'd0);
        check("pop_drained", 64'(sb.size()), 64'd0);

        // Redirect while the request to 8006 is outstanding
        ack_lat = 2;
        reset_dut();
        reset = 1'b0;
        n = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h8006) && n < 60) begin
            tick();
            n++;
        end
        check("reach_8006", 64'(bus.mem_addr), 64'h8006);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0101;
        #1;
        check("redir_no_valid", 64'(bus.instr_valid), 64'd0);
        check("redir_hold_addr", 64'(bus.mem_addr), 64'h8006);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("stale_hold_req", 64'({bus.mem_req, bus.mem_addr}), 64'h1_8006);
        n = 0;
        while (last_ack_addr !== 16'h8006 && n < 10) begin
            tick();
            n++;
        end
        check("redir_new_req", 64'({bus.mem_req, bus.mem_addr}), 64'h1_0100);
        expect_stream(16'h0100, 2);
        bus.instr_ready = 1'b1;
        drain("drain_redirect", 30);

        // Redirect and pop in the same cycle
        ack_lat = 0;
        repeat (8) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h2000;
        bus.instr_ready    = 1'b1;
        #1;
        check("rp_no_valid", 64'(bus.instr_valid), 64'd0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("rp_empty", 64'(bus.instr_valid), 64'd0);
        check("rp_pc", 64'(bus.instr_pc), 64'h2000);
        check("rp_req", 64'({bus.mem_req, bus.mem_addr}), 64'h1_2000);
        expect_stream(16'h2000, 3);
        bus.instr_ready = 1'b1;
        drain("drain_rp", 30);

        // 32-bit instruction straddling the address wrap, odd redirect target
        mem_img[16'hFFFC] = 16'h1111;
        mem_img[16'hFFFE] = 16'hE0AA;
        mem_img[16'h0000] = 16'h5555;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFD;
        tick();
        bus.redirect_valid = 1'b0;
        expect_stream(16'hFFFC, 3);
        bus.instr_ready = 1'b1;
        drain("drain_wrap", 30);

        // Reset while a request is outstanding
        mem_img.delete();
        mem_img[16'h8000] = 16'hABCD;
        ack_lat = 3;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_mid_req", 64'({bus.mem_req, bus.mem_addr}), 64'h1_8000);
        expect_stream(16'h8000, 2);
        bus.instr_ready = 1'b1;
        drain("drain_rst_mid", 40);

`ifdef SPCPU_FETCH_PERF_CNT_EN
        // Stall counter with a three-cycle memory delay
        mem_img.delete();
        ack_lat = 3;
        reset_dut();
        expect_stream(16'h8000, 1);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("stall_cnt", 64'(fetch_stall_cnt), 64'd4);
        drain("drain_perf", 20);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spcpu_fetch_unit.md
SPCPU_FETCH_UNIT -- requirements
Module: spcpu_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width.
REQ-002 Parameter DEPTH, default 4, halfword queue entries; power of 2, >=2.
REQ-003 Parameter RESET_PC, default 16'h8000, fetch address after reset.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 redirect_valid  in  1  PC change request (branch/call/PC write).
REQ-007 redirect_pc  in  ADDR_W  new fetch address; bit 0 forced to 0.
REQ-008 mem_req  out  1  halfword read request.
REQ-009 mem_addr  out  ADDR_W  request address, always even.
REQ-010 mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  in  16  returned halfword.
REQ-012 instr_valid  out  1  complete instruction at queue head.
REQ-013 instr_ready  in  1  consumer accepts the head instruction.
REQ-014 instr_hi  out  16  first halfword; instr_lo  out  16  second halfword, 0 for 16-bit instructions.
REQ-015 instr_is_32  out  1  head instruction is 32-bit.
REQ-016 instr_pc  out  ADDR_W  address of instr_hi.

Function
REQ-017 Queue SHALL hold up to DEPTH halfwords, each tagged with its address.
REQ-018 Max one request outstanding; mem_req SHALL assert when no request is pending and the free count, after any same-cycle pop, is >=1.
REQ-019 mem_req/mem_addr SHALL hold stable until the mem_ack cycle; fetch_pc SHALL advance by 2 on ack, wrapping modulo 2^ADDR_W.
REQ-020 Response SHALL be written to the queue tail on mem_ack unless marked stale.
REQ-021 A halfword is 32-bit iff (hi & LEN32_MASK) == LEN32_MATCH.
REQ-022 instr_valid SHALL be 1 when the head is 16-bit and occupancy >=1, or the head is 32-bit and occupancy >=2; otherwise 0.
REQ-023 On instr_valid & instr_ready, 1 or 2 entries SHALL pop; the next head is visible the following cycle.
REQ-024 Simultaneous push and pop SHALL both occur; occupancy SHALL never exceed DEPTH or drop below 0.
REQ-025 redirect_valid SHALL empty the queue, set fetch_pc = {redirect_pc[ADDR_W-1:1],0}, and suppress instr_valid in that cycle; redirect wins over same-cycle pop and push.
REQ-026 Redirect with a request pending: request held until ack; that response SHALL be discarded (stale flag); the new-address request issues the cycle after ack.
REQ-027 Redirect in the ack cycle SHALL discard that response.
REQ-028 A 32-bit instruction straddling the address wrap SHALL be delivered, instr_pc = 2^ADDR_W-2.
REQ-029 Redirect-to-first-request latency SHALL be 1 cycle when nothing is pending.

Reset
REQ-030 On reset: queue empty, fetch_pc=RESET_PC, stale=0, mem_req=0, instr_valid=0, instr_hi/lo=0, instr_is_32=0, instr_pc=RESET_PC.
REQ-031 Reset mid-request SHALL drop the pending request; a later mem_ack SHALL be ignored until a new request is issued.
REQ-032 First request SHALL issue the cycle after reset deasserts.

Configuration
REQ-033 Macro SPCPU_FETCH_PERF_CNT_EN: when defined, adds output fetch_stall_cnt (32 bits), reset 0, +1 each cycle instr_ready=1 and instr_valid=0, saturating at all-ones.
REQ-034 Without the macro: no port, no counter logic; all other behaviour identical.

Structure
REQ-035 Package pkg_fetch SHALL hold LEN32_MASK=16'hE000, LEN32_MATCH=16'hE000, and the is_32_bit(hi) function.
REQ-036 Queue storage/pointers SHALL be sub-module spcpu_fetch_queue (push, pop1, pop2, flush, count).
REQ-037 Core SHALL be integrated by replacing its instruction-load states with instr_valid/instr_ready.

Verification
REQ-038 Reset, memory acks every cycle, data 16'h1234,16'h5678 -> first mem_addr 16'h8000; instr_pc 8000/8002, instr_is_32=0.
REQ-039 Halfwords 16'hE001,16'hBEEF at 8000 -> single instr: hi E001, lo BEEF, is_32=1, pc 8000; next pc 8004.
REQ-040 instr_ready=0 with DEPTH=4 -> exactly 4 acks, then mem_req=0; one 16-bit pop -> mem_req=1 the next cycle.
REQ-041 Redirect to 16'h0101 while request to 8006 is pending -> 8006 data dropped, next mem_addr 16'h0100, first instr_pc 0100.
REQ-042 Redirect and pop in the same cycle -> queue empty, no instr_valid that cycle, pop ignored.
REQ-043 SPCPU_FETCH_PERF_CNT_EN with mem_ack delayed 3 cycles and instr_ready=1 -> fetch_stall_cnt == 4 at first instr_valid.
